vga_rect_compositor: RTL and testbench
======================================

Name: vga_rect_compositor

Overview:
- Parametrised successor to the single-screen pattern generator.
- Generates its own VGA timing and composites up to NUM_RECT runtime-programmable coloured rectangles over a background colour.
- Rectangle geometry and colour are written through a valid/ready config port into a pending bank. The pending bank is copied to the live bank only at a frame boundary, so no tearing occurs.
- Drives the board's h_sync/v_sync/RGB pins directly.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (pixels)
- H_SYNC, 120, horizontal sync width (pixels)
- H_BP, 64, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of h_sync/v_sync
- CLK_DIV, 1, clk cycles per pixel (1 = every cycle); pixel enable pe pulses once per CLK_DIV cycles
- NUM_RECT, 4, number of rectangle slots (1..16)
- COLOR_W, 1, bits per colour channel

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high together with cfg_valid
- cfg_idx  in  4  rectangle slot; values >= NUM_RECT are accepted and discarded
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  12 each  inclusive rectangle bounds
- cfg_color  in  3*COLOR_W  {r,g,b}
- cfg_en  in  1  slot enable
- commit  in  1  one-cycle pulse: request pending->live copy at next frame boundary
- bg_color  in  3*COLOR_W  background colour, sampled every pixel
- commit_pending  out  1  high from commit pulse until the copy is done
- frame_start  out  1  one-clk pulse at the first pe of pixel (0,0), aligned with output
- h_sync  out  1  horizontal sync
- v_sync  out  1  vertical sync
- r_out, g_out, b_out  out  COLOR_W each  colour channels

Behaviour:
- Reset (rst low, async) sets all outputs to these values:
  - h_sync = v_sync = !SYNC_POL
  - RGB = 0
  - frame_start = 0, commit_pending = 0
  - cfg_ready = 1
  - counters = 0
  - all pending and live slots disabled, coordinates 0
- Release of reset is synchronous to clk.
- Counters:
  - hc runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters.
  - vc runs 0..V_TOTAL-1 and increments when hc wraps.
  - Both advance only on pe and wrap to 0.
  - The frame boundary is the pe with hc = H_TOTAL-1 and vc = V_TOTAL-1.
- Sync timing:
  - h_sync is active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; vertical uses the same rule on vc.
  - active = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Pipeline: 3 stages, each advancing on pe.
  - S0: counters.
  - S1: registered per-slot hit = en && x0<=hc<=x1 && y0<=vc<=y1, plus delayed active/syncs.
  - S2: registered priority mux and outputs.
  - Latency is 2 pe from counter value to pins. Syncs, active and frame_start are delayed identically, so colour and syncs stay aligned.
- Colour selection:
  - Lowest-index hit slot wins.
  - No hit gives bg_color.
  - !active forces RGB = 0 (blanking takes precedence over everything).
- Degenerate rectangles:
  - x0>x1 or y0>y1 never hits.
  - Coordinates beyond the active area are legal; only the visible part is drawn.
  - x0=x1, y0=y1 draws exactly one pixel.
- Config handshake:
  - A write occurs on a cycle with cfg_valid && cfg_ready and updates the pending slot cfg_idx.
  - A write of the same slot on consecutive cycles ends with the last value.
  - The live bank is never written by the config port.
- Commit:
  - A commit pulse sets commit_pending.
  - At the frame boundary pe with commit_pending = 1, all slots copy pending->live in one cycle, and commit_pending clears the next cycle.
  - cfg_ready is 0 in that copy cycle only. A write presented then waits.
  - A commit arriving while already pending is absorbed (single copy).
  - A commit in the same cycle as the boundary copy sets commit_pending again for the next frame.
- Reset mid-frame:
  - Outputs go to reset values immediately.
  - The pending commit is lost.
  - Timing restarts at (0,0).

Test Plan:
- Reset then free-run at defaults with CLK_DIV=1 -> h_sync high for exactly 120 clks starting at clk 856 of each 1040-clk line; v_sync high for 6 lines every 666 lines; frame_start every 692,640 clks.
- Write slot0 (10,10)-(19,19) red, en=1; commit; bg=blue -> the first frame after the boundary shows red exactly at x,y in 10..19 (100 pixels/frame) and blue elsewhere in the active area; RGB=0 in blanking.
- Slot0 (0,0)-(99,99) red and slot1 (50,50)-(149,149) green, both enabled -> pixel (60,60) is red, (120,120) green, (100,100) green, (150,150) bg.
- Rewrite slot0 mid-frame without commit -> output is unchanged for all frames. Then commit at vc=300 -> the change appears first at frame_start and never mid-frame; commit_pending falls 1 clk after the boundary.
- Hold cfg_valid through the boundary copy cycle -> cfg_ready=0 for exactly 1 clk, write lands the next cycle; cfg_idx=7 with NUM_RECT=4 is accepted, no effect.
- CLK_DIV=2, x0=5 > x1=3 -> the line period doubles to 2080 clks and slot never draws; async rst low at hc=400 -> outputs at reset values within the same cycle, restart at (0,0).

Source files
------------

// File: rtl/vga_rect_compositor.sv
// VGA timing generator that composites NUM_RECT programmable rectangles over a background.
// Config writes land in a pending bank that is copied to the live bank at a frame boundary.
module vga_rect_compositor #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1,
  parameter int CLK_DIV  = 1,
  parameter int NUM_RECT = 4,
  parameter int COLOR_W  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_idx,
  input  logic [11:0]          cfg_x0,
  input  logic [11:0]          cfg_y0,
  input  logic [11:0]          cfg_x1,
  input  logic [11:0]          cfg_y1,
  input  logic [3*COLOR_W-1:0] cfg_color,
  input  logic                 cfg_en,
  input  logic                 commit,
  input  logic [3*COLOR_W-1:0] bg_color,
  output logic                 commit_pending,
  output logic                 frame_start,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [COLOR_W-1:0]   r_out,
  output logic [COLOR_W-1:0]   g_out,
  output logic [COLOR_W-1:0]   b_out
);
  localparam int CW    = 12;
  localparam int RGB_W = 3 * COLOR_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);

  typedef struct packed {
    logic             en;
    logic [CW-1:0]    x0;
    logic [CW-1:0]    y0;
    logic [CW-1:0]    x1;
    logic [CW-1:0]    y1;
    logic [RGB_W-1:0] color;
  } rect_t;

  logic [DIV_W-1:0] div_cnt;
  logic             pe;
  logic [CW-1:0]    hc, vc;
  logic             copy;

  assign pe = (div_cnt == '0);
  // Copy happens on the last pixel of the frame so the new bank is in place for pixel (0,0).
  assign copy      = pe && (hc == H_LAST) && (vc == V_LAST) && commit_pending;
  assign cfg_ready = !copy;

  // NOTE: every sequential block uses non-blocking assignments so all state updates
  // see pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      hc      <= '0;
      vc      <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
      if (pe) begin
        if (hc == H_LAST) begin
          hc <= '0;
          vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
        end else begin
          hc <= hc + 1'b1;
        end
      end
    end
  end

  rect_t pend [NUM_RECT];
  rect_t live [NUM_RECT];

  // NOTE: the banks are a handful of registers, not RAM, so every slot is reset
  // explicitly and comes up disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_RECT; i++) begin
        pend[i] <= '0;
        live[i] <= '0;
      end
    end else begin
      if (commit)    commit_pending <= 1'b1;
      else if (copy) commit_pending <= 1'b0;
      for (int i = 0; i < NUM_RECT; i++) begin
        if (cfg_valid && cfg_ready && cfg_idx == 4'(i))
          pend[i] <= '{en: cfg_en, x0: cfg_x0, y0: cfg_y0, x1: cfg_x1, y1: cfg_y1,
                       color: cfg_color};
        if (copy) live[i] <= pend[i];
      end
    end
  end

  logic [NUM_RECT-1:0] hit_1;
  logic [RGB_W-1:0]    color_1 [NUM_RECT];
  logic                active_1, hs_1, vs_1, fs_1;

  // Colours travel with the hit flags so a bank swap cannot split one pixel across banks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_1    <= '0;
      active_1 <= 1'b0;
      hs_1     <= 1'b0;
      vs_1     <= 1'b0;
      fs_1     <= 1'b0;
      for (int i = 0; i < NUM_RECT; i++) color_1[i] <= '0;
    end else if (pe) begin
      for (int i = 0; i < NUM_RECT; i++) begin
        hit_1[i]   <= live[i].en && (live[i].x0 <= hc) && (hc <= live[i].x1)
                                 && (live[i].y0 <= vc) && (vc <= live[i].y1);
        color_1[i] <= live[i].color;
      end
      active_1 <= (hc < H_ACT) && (vc < V_ACT);
      hs_1     <= (hc >= HS_START) && (hc < HS_END);
      vs_1     <= (vc >= VS_START) && (vc < VS_END);
      fs_1     <= (hc == '0) && (vc == '0);
    end
  end

  logic [RGB_W-1:0] pix;

  // NOTE: pix gets its default before any condition, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    pix = bg_color;
    for (int i = NUM_RECT - 1; i >= 0; i--) begin
      if (hit_1[i]) pix = color_1[i];
    end
    if (!active_1) pix = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_sync                <= !SYNC_ON;
      v_sync                <= !SYNC_ON;
      {r_out, g_out, b_out} <= '0;
      frame_start           <= 1'b0;
    end else begin
      frame_start <= pe && fs_1;
      if (pe) begin
        h_sync                <= hs_1 ? SYNC_ON : !SYNC_ON;
        v_sync                <= vs_1 ? SYNC_ON : !SYNC_ON;
        {r_out, g_out, b_out} <= pix;
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_compositor.sv
// Directed bench for vga_rect_compositor using a shrunken 24x16 raster so whole frames fit.
module tb_vga_rect_compositor;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 12, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;   // 24
  localparam int VT = VA + VF + VS + VB;   // 16
  localparam logic [2:0] RED = 3'b100, GREEN = 3'b010, BLUE = 3'b001;
  localparam logic [2:0] WHITE = 3'b111, YEL = 3'b110, CYAN = 3'b011;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] c;
  } pv_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cfg_valid = 1'b0, cfg_en = 1'b0, commit = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [11:0] cfg_x0 = '0, cfg_y0 = '0, cfg_x1 = '0, cfg_y1 = '0;
  logic [2:0]  cfg_color = '0, bg_color = '0;

  logic rdy, cp, fs, hs, vs, r, g, b;
  logic rdy2, cp2, fs2, hs2, vs2, r2, g2, b2;

  int vectors = 0, miscompares = 0;
  logic [2:0] pix [VT][HT];
  logic       hsa [VT][HT];
  logic       vsa [VT][HT];
  int         fs_cnt;

  always #5 clk = ~clk;

  vga_rect_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .CLK_DIV(1), .NUM_RECT(4), .COLOR_W(1)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy), .cfg_idx(cfg_idx),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .commit(commit), .bg_color(bg_color),
    .commit_pending(cp), .frame_start(fs), .h_sync(hs), .v_sync(vs),
    .r_out(r), .g_out(g), .b_out(b)
  );

  vga_rect_compositor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1), .CLK_DIV(2), .NUM_RECT(4), .COLOR_W(1)
  ) dut2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy2), .cfg_idx(cfg_idx),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_x1(cfg_x1), .cfg_y1(cfg_y1),
    .cfg_color(cfg_color), .cfg_en(cfg_en), .commit(commit), .bg_color(bg_color),
    .commit_pending(cp2), .frame_start(fs2), .h_sync(hs2), .v_sync(vs2),
    .r_out(r2), .g_out(g2), .b_out(b2)
  );

  task automatic cfg_write(input logic [3:0] idx, input logic [11:0] x0, input logic [11:0] y0,
                           input logic [11:0] x1, input logic [11:0] y1,
                           input logic [2:0] c, input logic en);
    int guard = 0;
    cfg_valid = 1'b1; cfg_idx = idx; cfg_en = en; cfg_color = c;
    cfg_x0 = x0; cfg_y0 = y0; cfg_x1 = x1; cfg_y1 = y1;
    while (rdy !== 1'b1 && guard < 8) begin @(negedge clk); guard++; end
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++; $display("FAIL cfg_accept slot %0d: cfg_ready=%b expected 1", idx, rdy);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Waits for frame_start (including the current sample) and records one full frame.
  task automatic capture_frame();
    int guard = 0;
    while (fs !== 1'b1 && guard < 2 * HT * VT) begin @(negedge clk); guard++; end
    vectors++;
    if (fs !== 1'b1) begin
      miscompares++; $display("FAIL frame_sync: frame_start=%b expected 1 within %0d clks", fs, guard);
    end
    fs_cnt = 0;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        pix[y][x] = {r, g, b}; hsa[y][x] = hs; vsa[y][x] = vs;
        if (fs === 1'b1) fs_cnt++;
        @(negedge clk);
      end
    end
    vectors++;
    if (fs !== 1'b1) begin
      miscompares++; $display("FAIL frame_period: frame_start=%b at clk %0d expected 1", fs, HT * VT);
    end
  endtask

  function automatic int count_rgb(input logic [2:0] c);
    int n = 0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (pix[y][x] === c) n++;
    return n;
  endfunction

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({hs, vs, r, g, b, fs, cp, rdy} !== 8'b0000_0001) begin
      miscompares++; $display("FAIL reset_outputs: got %b expected 00000001", {hs, vs, r, g, b, fs, cp, rdy});
    end
    vectors++;
    if ({hs2, vs2, r2, g2, b2, fs2, cp2, rdy2} !== 8'b0000_0001) begin
      miscompares++; $display("FAIL reset_outputs_div2: got %b expected 00000001",
                              {hs2, vs2, r2, g2, b2, fs2, cp2, rdy2});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_timing();
    int bad_h = 0, bad_v = 0, bad_p = 0, n_h = 0, n_v = 0;
    bg_color = BLUE;
    capture_frame();
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        if (hsa[y][x] !== ((x >= HA + HF) && (x < HA + HF + HS))) bad_h++;
        if (vsa[y][x] !== ((y >= VA + VF) && (y < VA + VF + VS))) bad_v++;
        if (pix[y][x] !== ((x < HA && y < VA) ? BLUE : 3'b000)) bad_p++;
        if (hsa[y][x] === 1'b1) n_h++;
        if (vsa[y][x] === 1'b1) n_v++;
      end
    end
    vectors++;
    if (bad_h != 0) begin miscompares++; $display("FAIL hsync_map: %0d wrong samples expected 0", bad_h); end
    vectors++;
    if (bad_v != 0) begin miscompares++; $display("FAIL vsync_map: %0d wrong samples expected 0", bad_v); end
    vectors++;
    if (bad_p != 0) begin miscompares++; $display("FAIL blank_map: %0d wrong pixels expected 0", bad_p); end
    vectors++;
    if (n_h != HS * VT) begin miscompares++; $display("FAIL hsync_count: got %0d expected %0d", n_h, HS * VT); end
    vectors++;
    if (n_v != VS * HT) begin miscompares++; $display("FAIL vsync_count: got %0d expected %0d", n_v, VS * HT); end
    vectors++;
    if (fs_cnt != 1) begin miscompares++; $display("FAIL frame_start_width: got %0d expected 1", fs_cnt); end
  endtask

  task automatic test_single_rect();
    pv_t v [9];
    cfg_write(4'd0, 12'd2, 12'd2, 12'd4, 12'd4, RED, 1'b1);
    do_commit();
    capture_frame();
    v = '{'{2, 2, RED}, '{4, 4, RED}, '{3, 3, RED}, '{5, 4, BLUE}, '{1, 2, BLUE},
          '{3, 5, BLUE}, '{4, 1, BLUE}, '{16, 3, 3'b000}, '{3, 12, 3'b000}};
    foreach (v[i]) begin
      vectors++;
      if (pix[v[i].y][v[i].x] !== v[i].c) begin
        miscompares++;
        $display("FAIL single_pixel(%0d,%0d): got %b expected %b", v[i].x, v[i].y, pix[v[i].y][v[i].x], v[i].c);
      end
    end
    vectors++;
    if (count_rgb(RED) != 9) begin miscompares++; $display("FAIL single_red_count: got %0d expected 9", count_rgb(RED)); end
    vectors++;
    if (count_rgb(BLUE) != 183) begin miscompares++; $display("FAIL single_bg_count: got %0d expected 183", count_rgb(BLUE)); end
    vectors++;
    if (cp !== 1'b0) begin miscompares++; $display("FAIL single_pending_clear: got %b expected 0", cp); end
  endtask

  task automatic test_priority();
    pv_t v [12];
    cfg_write(4'd0, 12'd0, 12'd0, 12'd7, 12'd7, RED, 1'b1);
    cfg_write(4'd1, 12'd4, 12'd4, 12'd11, 12'd11, GREEN, 1'b1);
    cfg_write(4'd2, 12'd0, 12'd0, 12'd15, 12'd11, WHITE, 1'b0);
    cfg_write(4'd3, 12'd14, 12'd0, 12'd100, 12'd0, CYAN, 1'b1);
    do_commit();
    capture_frame();
    v = '{'{5, 5, RED}, '{7, 7, RED}, '{0, 0, RED}, '{10, 10, GREEN}, '{8, 8, GREEN},
          '{11, 11, GREEN}, '{12, 11, BLUE}, '{8, 3, BLUE}, '{15, 0, CYAN}, '{13, 0, BLUE},
          '{15, 1, BLUE}, '{16, 0, 3'b000}};
    foreach (v[i]) begin
      vectors++;
      if (pix[v[i].y][v[i].x] !== v[i].c) begin
        miscompares++;
        $display("FAIL prio_pixel(%0d,%0d): got %b expected %b", v[i].x, v[i].y, pix[v[i].y][v[i].x], v[i].c);
      end
    end
    vectors++;
    if (count_rgb(GREEN) != 48) begin miscompares++; $display("FAIL prio_green_count: got %0d expected 48", count_rgb(GREEN)); end
    vectors++;
    if (count_rgb(BLUE) != 78) begin miscompares++; $display("FAIL prio_bg_count: got %0d expected 78", count_rgb(BLUE)); end
  endtask

  task automatic test_no_commit();
    int k = 0, k_fall = -1;
    cfg_write(4'd0, 12'd0, 12'd0, 12'd15, 12'd11, WHITE, 1'b1);
    capture_frame();
    vectors++;
    if (pix[5][5] !== RED || pix[10][10] !== GREEN) begin
      miscompares++; $display("FAIL uncommitted_leak: got %b/%b expected %b/%b", pix[5][5], pix[10][10], RED, GREEN);
    end
    // Now at pixel (0,0) of a new frame; commit near line 6 and watch it land at the boundary.
    while (k < 2 * HT * VT) begin
      if (k == 150) commit = 1'b1;
      if (k == 151) begin
        commit = 1'b0;
        vectors++;
        if (cp !== 1'b1) begin miscompares++; $display("FAIL pending_set: got %b expected 1", cp); end
      end
      if (k == 10 * HT + 10) begin
        vectors++;
        if ({r, g, b} !== GREEN) begin miscompares++; $display("FAIL mid_frame_tear: got %b expected %b", {r, g, b}, GREEN); end
      end
      if (k > 151 && k_fall < 0 && cp === 1'b0) k_fall = k;
      if (k_fall >= 0 && fs === 1'b1) break;
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k_fall != HT * VT - 2) begin miscompares++; $display("FAIL pending_fall: got clk %0d expected %0d", k_fall, HT * VT - 2); end
    vectors++;
    if (k != HT * VT) begin miscompares++; $display("FAIL commit_frame_start: got clk %0d expected %0d", k, HT * VT); end
    capture_frame();
    vectors++;
    if (count_rgb(WHITE) != HA * VA) begin miscompares++; $display("FAIL commit_white_count: got %0d expected %0d", count_rgb(WHITE), HA * VA); end
  endtask

  task automatic test_back_to_back();
    pv_t v [5];
    int guard = 0;
    do_commit();
    while (rdy !== 1'b0 && guard < 2 * HT * VT) begin @(negedge clk); guard++; end
    vectors++;
    if (rdy !== 1'b0 || cp !== 1'b1) begin
      miscompares++; $display("FAIL copy_cycle: ready/pending got %b%b expected 01", rdy, cp);
    end
    cfg_valid = 1'b1; cfg_idx = 4'd0; cfg_en = 1'b1; cfg_color = RED;
    cfg_x0 = 12'd3; cfg_y0 = 12'd3; cfg_x1 = 12'd3; cfg_y1 = 12'd3;
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    vectors++;
    if (rdy !== 1'b1) begin miscompares++; $display("FAIL ready_low_width: got %b expected 1", rdy); end
    vectors++;
    if (cp !== 1'b1) begin miscompares++; $display("FAIL commit_on_copy: got %b expected 1", cp); end
    @(negedge clk);
    cfg_idx = 4'd7; cfg_color = YEL; cfg_x0 = 12'd0; cfg_y0 = 12'd0; cfg_x1 = 12'd15; cfg_y1 = 12'd11;
    @(negedge clk);
    cfg_valid = 1'b0;
    capture_frame();
    vectors++;
    if (count_rgb(WHITE) != HA * VA) begin miscompares++; $display("FAIL held_write_leak: got %0d white expected %0d", count_rgb(WHITE), HA * VA); end
    capture_frame();
    v = '{'{3, 3, RED}, '{4, 4, GREEN}, '{2, 2, BLUE}, '{3, 4, BLUE}, '{15, 0, CYAN}};
    foreach (v[i]) begin
      vectors++;
      if (pix[v[i].y][v[i].x] !== v[i].c) begin
        miscompares++;
        $display("FAIL b2b_pixel(%0d,%0d): got %b expected %b", v[i].x, v[i].y, pix[v[i].y][v[i].x], v[i].c);
      end
    end
    vectors++;
    if (count_rgb(RED) != 1) begin miscompares++; $display("FAIL b2b_red_count: got %0d expected 1", count_rgb(RED)); end
    vectors++;
    if (count_rgb(YEL) != 0) begin miscompares++; $display("FAIL bad_idx_write: got %0d yellow expected 0", count_rgb(YEL)); end
  endtask

  task automatic test_degenerate();
    cfg_write(4'd0, 12'd5, 12'd0, 12'd3, 12'd11, RED, 1'b1);
    cfg_write(4'd1, 12'd0, 12'd5, 12'd15, 12'd3, GREEN, 1'b1);
    cfg_write(4'd2, 12'd9, 12'd1, 12'd9, 12'd1, YEL, 1'b1);
    cfg_write(4'd3, 12'd0, 12'd0, 12'd15, 12'd11, WHITE, 1'b0);
    do_commit();
    capture_frame();
    vectors++;
    if (pix[1][9] !== YEL) begin miscompares++; $display("FAIL one_pixel: got %b expected %b", pix[1][9], YEL); end
    vectors++;
    if (count_rgb(YEL) != 1) begin miscompares++; $display("FAIL one_pixel_count: got %0d expected 1", count_rgb(YEL)); end
    vectors++;
    if (count_rgb(BLUE) != HA * VA - 1) begin miscompares++; $display("FAIL degenerate_bg: got %0d expected %0d", count_rgb(BLUE), HA * VA - 1); end
  endtask

  task automatic test_clk_div();
    int t = 0, hi = 0, per = 0, fper = 1;
    logic prev;
    prev = hs2;
    while (!(prev === 1'b0 && hs2 === 1'b1) && t < 400) begin prev = hs2; @(negedge clk); t++; end
    while (hs2 === 1'b1 && hi < 400) begin @(negedge clk); hi++; end
    per = hi;
    while (hs2 === 1'b0 && per < 400) begin @(negedge clk); per++; end
    vectors++;
    if (hi != 2 * HS) begin miscompares++; $display("FAIL div2_hsync_width: got %0d expected %0d", hi, 2 * HS); end
    vectors++;
    if (per != 2 * HT) begin miscompares++; $display("FAIL div2_line_period: got %0d expected %0d", per, 2 * HT); end
    t = 0;
    while (fs2 !== 1'b1 && t < 4 * HT * VT) begin @(negedge clk); t++; end
    @(negedge clk);
    vectors++;
    if (fs2 !== 1'b0) begin miscompares++; $display("FAIL div2_fs_width: got %b expected 0", fs2); end
    while (fs2 !== 1'b1 && fper < 4 * HT * VT) begin @(negedge clk); fper++; end
    vectors++;
    if (fper != 2 * HT * VT) begin miscompares++; $display("FAIL div2_frame_period: got %0d expected %0d", fper, 2 * HT * VT); end
  endtask

  task automatic test_reset_midframe();
    int guard = 0;
    while (fs !== 1'b1 && guard < 2 * HT * VT) begin @(negedge clk); guard++; end
    repeat (10) @(negedge clk);
    do_commit();
    repeat ((VA + VF) * HT + HA + HF + 1 - 11) @(negedge clk);
    vectors++;
    if ({hs, vs, cp} !== 3'b111) begin miscompares++; $display("FAIL pre_reset_state: got %b expected 111", {hs, vs, cp}); end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({hs, vs, r, g, b, fs, cp, rdy} !== 8'b0000_0001) begin
      miscompares++; $display("FAIL midframe_reset: got %b expected 00000001", {hs, vs, r, g, b, fs, cp, rdy});
    end
    vectors++;
    if ({hs2, vs2, r2, g2, b2, cp2} !== 6'b0) begin
      miscompares++; $display("FAIL midframe_reset_div2: got %b expected 000000", {hs2, vs2, r2, g2, b2, cp2});
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({fs, fs2} !== 2'b10) begin miscompares++; $display("FAIL restart_fs: got %b expected 10", {fs, fs2}); end
    @(negedge clk);
    vectors++;
    if (fs2 !== 1'b1) begin miscompares++; $display("FAIL restart_fs_div2: got %b expected 1", fs2); end
    capture_frame();
    vectors++;
    if (count_rgb(BLUE) != HA * VA) begin miscompares++; $display("FAIL reset_clears_live: got %0d bg expected %0d", count_rgb(BLUE), HA * VA); end
    vectors++;
    if (cp !== 1'b0) begin miscompares++; $display("FAIL reset_drops_commit: got %b expected 0", cp); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_single_rect();
    test_priority();
    test_no_commit();
    test_back_to_back();
    test_degenerate();
    test_clk_div();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
